spi_flash_responder: RTL and testbench

SPI Mode 0 target that emulates a serial flash's READ path. It serves the 6809 flash controller, or any SPI master, from a local byte memory through a synchronous read port. The block oversamples SCK, MOSI and CS on the system clock. It decodes the command byte, captures a 24-bit address, and streams bytes out on MISO with auto-increment until CS deasserts. It is used as an on-FPGA boot-ROM stand-in and as a bench partner for the flash controller.

---
 rtl/spi_flash_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI Mode 0 target emulating the READ path of a serial flash.
// SCK, MOSI and CS are oversampled on clk through 2-FF synchronizers.
// Command 0x03 takes a 24-bit address and streams bytes from local memory,
// auto-incrementing the address. Command 0x05 returns STATUS_BYTE repeatedly.
// Any other command is flagged on o_CMD_ERR and ignored until CS rises.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   i_SPI_CLK    SPI clock from the master (asynchronous to clk)
//   i_SPI_MOSI   master-out data
//   i_SPI_CS     chip select, active low
//   o_SPI_MISO   slave-out data
//   o_MISO_OE    MISO output enable (pad tristated when 0)
//   o_MEM_ADDR   local memory read address
//   o_MEM_RD     one-cycle read strobe
//   i_MEM_DATA   read data, valid one clk after o_MEM_RD
//   o_Active     high while a recognised command is in progress
//   o_CMD_ERR    one-cycle pulse when an unsupported command completes
module spi_flash_responder #(
    parameter int unsigned ADDR_W      = 12,
    parameter logic [7:0]  STATUS_BYTE = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_SPI_CLK,
    input  logic              i_SPI_MOSI,
    input  logic              i_SPI_CS,
    output logic              o_SPI_MISO,
    output logic              o_MISO_OE,
    output logic [ADDR_W-1:0] o_MEM_ADDR,
    output logic              o_MEM_RD,
    input  logic [7:0]        i_MEM_DATA,
    output logic              o_Active,
    output logic              o_CMD_ERR
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StStat,
        StIgnore
    } state_e;

    // Synchronizers and edge detection
    logic [1:0] sck_sync_q;
    logic       sck_dly_q;
    logic [1:0] mosi_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] flush_q;
    logic       cs_hi_q;

    logic sck_s, mosi_s, cs_s;
    logic sck_rise, sck_fall, cs_fall;

    assign sck_s    = sck_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign cs_s     = cs_sync_q[1];
    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;
    // cs_hi_q only reports CS high once the preset synchronizer values have
    // flushed, so a CS held low across reset never looks like a falling edge.
    assign cs_fall  = cs_hi_q & ~cs_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q  <= 2'b00;
            sck_dly_q   <= 1'b0;
            mosi_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            flush_q     <= 2'b00;
            cs_hi_q     <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], i_SPI_CLK};
            sck_dly_q   <= sck_s;
            mosi_sync_q <= {mosi_sync_q[0], i_SPI_MOSI};
            cs_sync_q   <= {cs_sync_q[0], i_SPI_CS};
            flush_q     <= {flush_q[0], 1'b1};
            cs_hi_q     <= cs_s & flush_q[1];
        end
    end

    // Main FSM and datapath
    state_e            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              ld_q, ld_d;
    logic              err_q, err_d;
    logic [23:0]       shift_in;

    assign shift_in = {shift_q[22:0], mosi_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= 5'd0;
            shift_q   <= 24'd0;
            tx_q      <= 8'd0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            ld_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            ld_q      <= ld_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        addr_d    = addr_q;
        rd_d      = 1'b0;
        ld_d      = rd_q;
        err_d     = 1'b0;

        // Memory data arrives one cycle after the strobe; SCK phases of at
        // least 4 clk guarantee this lands before the next SCK fall.
        if (ld_q) begin
            tx_d = i_MEM_DATA;
        end

        case (state_q)
            StIdle: begin
                oe_d   = 1'b0;
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = StCmd;
                    bit_cnt_d = 5'd0;
                end
            end
            StCmd: begin
                if (sck_rise) begin
                    shift_d = shift_in;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        case (shift_in[7:0])
                            8'h03: state_d = StAddr;
                            8'h05: begin
                                state_d = StStat;
                                tx_d    = STATUS_BYTE;
                            end
                            default: begin
                                state_d = StIgnore;
                                err_d   = 1'b1;
                            end
                        endcase
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            StAddr: begin
                if (sck_rise) begin
                    shift_d = shift_in;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = 5'd0;
                        addr_d    = shift_in[ADDR_W-1:0];
                        rd_d      = 1'b1;
                        state_d   = StData;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            StData: begin
                if (sck_rise) begin
                    if (bit_cnt_q == 5'd7) begin
                        // Prefetch the next byte; address wraps at 2^ADDR_W.
                        bit_cnt_d = 5'd0;
                        addr_d    = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        rd_d      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                if (sck_fall) begin
                    oe_d   = 1'b1;
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
            end
            StStat: begin
                // Rotate so the status byte repeats every 8 bits.
                if (sck_fall) begin
                    oe_d   = 1'b1;
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], tx_q[7]};
                end
            end
            StIgnore: begin
                oe_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // CS high overrides everything, including an SCK edge this cycle.
        if (cs_s) begin
            state_d   = StIdle;
            bit_cnt_d = 5'd0;
            oe_d      = 1'b0;
            miso_d    = 1'b0;
            rd_d      = 1'b0;
            ld_d      = 1'b0;
            err_d     = 1'b0;
        end
    end

    assign o_SPI_MISO = miso_q;
    assign o_MISO_OE  = oe_q;
    assign o_MEM_ADDR = addr_q;
    assign o_MEM_RD   = rd_q;
    assign o_CMD_ERR  = err_q;
    assign o_Active   = (state_q == StCmd) || (state_q == StAddr) ||
                        (state_q == StData) || (state_q == StStat);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed plus randomized bench for spi_flash_responder. A byte-array memory
// model answers reads; expected data and read addresses come from
// (address + index) mod 4096 over that array.
module tb_spi_flash_responder;

    localparam int unsigned ADDR_W = 12;
    localparam int          MEM_SZ = 4096;
    localparam logic [7:0]  STATUS = 8'h5A;
    localparam int          HALF   = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              spi_sck = 1'b0;
    logic              spi_mosi = 1'b0;
    logic              spi_cs = 1'b1;
    logic              spi_miso, miso_oe, mem_rd, active, cmd_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;

    logic [7:0]        mem [MEM_SZ];
    logic [7:0]        rx [8];
    logic [ADDR_W-1:0] rd_log [$];
    int vectors = 0;
    int miscompares = 0;
    int rd_count = 0;
    int err_count = 0;
    int oe_count = 0;

    spi_flash_responder #(
        .ADDR_W      (ADDR_W),
        .STATUS_BYTE (STATUS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_SPI_CLK  (spi_sck),
        .i_SPI_MOSI (spi_mosi),
        .i_SPI_CS   (spi_cs),
        .o_SPI_MISO (spi_miso),
        .o_MISO_OE  (miso_oe),
        .o_MEM_ADDR (mem_addr),
        .o_MEM_RD   (mem_rd),
        .i_MEM_DATA (mem_rdata),
        .o_Active   (active),
        .o_CMD_ERR  (cmd_err)
    );

    always #5 clk = ~clk;

    // Synchronous read port; garbage when not strobed so mistimed loads show.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        else        mem_rdata <= 8'($urandom);
    end

    always @(negedge clk) begin
        if (mem_rd) begin
            rd_count++;
            rd_log.push_back(mem_addr);
        end
        if (cmd_err) err_count++;
        if (miso_oe) oe_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [23:0] addr, input int k);
        return mem[(int'(addr) + k) % MEM_SZ];
    endfunction

    task automatic spi_bit(input logic mo, output logic mi);
        spi_mosi = mo;
        repeat (HALF) @(negedge clk);
        mi = spi_miso;
        spi_sck = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(mo[i], b);
            mi[i] = b;
        end
    endtask

    task automatic cs_begin();
        repeat (HALF) @(negedge clk);
        spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        spi_cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic read_txn(input logic [23:0] addr, input int n);
        logic [7:0] d;
        cs_begin();
        spi_byte(8'h03, d);
        check("active_after_cmd", active, 1);
        spi_byte(addr[23:16], d);
        spi_byte(addr[15:8], d);
        spi_byte(addr[7:0], d);
        check("active_after_addr", active, 1);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, rx[i]);
            check("active_in_data", active, 1);
        end
        cs_end();
        check("active_after_cs", active, 0);
    endtask

    initial begin
        logic [7:0]  d;
        logic        b;
        logic [23:0] a;
        int          n, rd_base, err_base, oe_base, hits;

        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_miso", spi_miso, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_active", active, 0);
        check("rst_err", cmd_err, 0);
        check("rst_addr", mem_addr, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte read from 0x123
        mem[12'h123] = 8'hA5;
        rd_base = rd_count;
        read_txn(24'h000123, 1);
        check("t1_byte", rx[0], 8'hA5);
        hits = 0;
        for (int i = rd_base; i < rd_count; i++) if (rd_log[i] == 12'h123) hits++;
        check("t1_reads_at_123", hits, 1);
        check("t1_first_rd_addr", rd_log[rd_base], 12'h123);

        // Wrap from 0xFFF to 0x000, upper address bits ignored
        mem[12'hFFE] = 8'h11;
        mem[12'hFFF] = 8'h22;
        mem[12'h000] = 8'h33;
        read_txn(24'hFFFFFE, 3);
        check("t2_byte0", rx[0], 8'h11);
        check("t2_byte1", rx[1], 8'h22);
        check("t2_byte2", rx[2], 8'h33);

        // Unsupported command
        rd_base = rd_count; err_base = err_count; oe_base = oe_count;
        cs_begin();
        spi_byte(8'h9F, d);
        check("t3_active", active, 0);
        spi_byte(8'($urandom), d);
        spi_byte(8'($urandom), d);
        check("t3_err_pulses", err_count - err_base, 1);
        check("t3_oe", oe_count - oe_base, 0);
        check("t3_reads", rd_count - rd_base, 0);
        check("t3_active_end", active, 0);
        cs_end();

        // Status read
        rd_base = rd_count;
        cs_begin();
        spi_byte(8'h05, d);
        check("t4_active", active, 1);
        spi_byte(8'h00, rx[0]);
        spi_byte(8'h00, rx[1]);
        check("t4_byte0", rx[0], STATUS);
        check("t4_byte1", rx[1], STATUS);
        check("t4_reads", rd_count - rd_base, 0);
        cs_end();

        // Aborted address phase, then a fresh read
        rd_base = rd_count;
        cs_begin();
        spi_byte(8'h03, d);
        for (int i = 0; i < 12; i++) spi_bit(1'($urandom), b);
        cs_end();
        check("t5_abort_reads", rd_count - rd_base, 0);
        mem[12'h010] = 8'h7E;
        read_txn(24'h000010, 1);
        check("t5_byte", rx[0], 8'h7E);

        // Reset in the middle of DATA with CS held low
        a = 24'($urandom);
        cs_begin();
        spi_byte(8'h03, d);
        spi_byte(a[23:16], d);
        spi_byte(a[15:8], d);
        spi_byte(a[7:0], d);
        spi_byte(8'h00, d);
        check("t6_byte", d, ref_byte(a, 0));
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_oe", miso_oe, 0);
        check("t6_miso", spi_miso, 0);
        check("t6_active", active, 0);
        check("t6_rd", mem_rd, 0);
        check("t6_addr", mem_addr, 0);
        rd_base = rd_count; oe_base = oe_count; err_base = err_count;
        spi_byte(8'($urandom), d);
        check("t6_post_oe", oe_count - oe_base, 0);
        check("t6_post_reads", rd_count - rd_base, 0);
        check("t6_post_err", err_count - err_base, 0);
        check("t6_post_active", active, 0);
        cs_end();
        a = 24'($urandom);
        read_txn(a, 1);
        check("t6_recover", rx[0], ref_byte(a, 0));

        // Randomized reads and stray commands
        for (int t = 0; t < 12; t++) begin
            if (t % 4 == 3) begin
                d = 8'($urandom);
                if (d == 8'h03 || d == 8'h05) d = 8'hAB;
                err_base = err_count; rd_base = rd_count; oe_base = oe_count;
                cs_begin();
                spi_byte(d, rx[0]);
                spi_byte(8'($urandom), rx[0]);
                cs_end();
                check("rnd_err", err_count - err_base, 1);
                check("rnd_err_reads", rd_count - rd_base, 0);
                check("rnd_err_oe", oe_count - oe_base, 0);
            end else begin
                a = 24'($urandom);
                n = $urandom_range(1, 3);
                for (int k = 0; k <= n; k++) mem[(int'(a) + k) % MEM_SZ] = 8'($urandom);
                rd_base = rd_count;
                read_txn(a, n);
                for (int k = 0; k < n; k++) check("rnd_byte", rx[k], ref_byte(a, k));
                check("rnd_read_count", rd_count - rd_base, n + 1);
                if (rd_count - rd_base == n + 1) begin
                    for (int k = 0; k <= n; k++)
                        check("rnd_rd_addr", rd_log[rd_base + k], (int'(a) + k) % MEM_SZ);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
